// File: rtl/display_pkg.sv
// Shared types for the multiplexed 4-digit display scanner: FSM states,
// digit index and the value/dp/enable/lzb register captured on load.
package display_pkg;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  typedef logic [1:0] digit_t;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lzb;
  } disp_t;

  localparam disp_t DISP_RESET = '{value: 16'h0000, dp: 4'h0, en: 4'hF, lzb: 1'b0};

  // Digit 0 is never blanked as a leading zero so a zero value still shows "0".
  function automatic logic digit_dark(input disp_t d, input digit_t k);
    logic lz;
    lz = 1'b0;
    case (k)
      2'd3:    lz = (d.value[15:12] == 4'h0);
      2'd2:    lz = (d.value[15:8] == 8'h00);
      2'd1:    lz = (d.value[15:4] == 12'h000);
      default: lz = 1'b0;
    endcase
    return !d.en[k] || (d.lzb && lz);
  endfunction

endpackage

// File: rtl/slot_counter.sv
// Per-digit slot timer and digit index; wrap marks the last cycle of a slot,
// frame marks the last cycle of the digit-3 slot.
module slot_counter
  import display_pkg::*;
#(
  parameter int SLOT_CYCLES = 65536,
  parameter int CW          = $clog2(SLOT_CYCLES)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  output logic [CW-1:0] count,
  output digit_t        digit,
  output logic          wrap,
  output logic          frame
);

  assign wrap  = (count == CW'(SLOT_CYCLES - 1));
  assign frame = wrap && (digit == 2'd3);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count <= '0;
      digit <= 2'd0;
    end else if (wrap) begin
      count <= '0;
      digit <= digit + 2'd1;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed 4-digit display driver with blanking gap, leading-zero
// blanking and frame-synchronous (tear-free) loading of new content.
module display_scan
  import display_pkg::*;
#(
  parameter int SLOT_CYCLES  = 65536,
  parameter int BLANK_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic [3:0]  digit_en_i,
  input  logic        lzb_i,
  input  logic        load_i,
  output logic        load_ack_o,
  output logic [3:0]  nibble_o,
  output logic        dp_o,
  output logic [3:0]  an_o,
  output logic        frame_o
);

  localparam int CW = $clog2(SLOT_CYCLES);

  logic [CW-1:0] count;
  digit_t        digit;
  logic          wrap;
  logic          frame;
  state_t        state_q, state_d;
  disp_t         disp_q, pend_q, load_in;
  logic          pend_vld;
  logic          dark;

  slot_counter #(.SLOT_CYCLES(SLOT_CYCLES), .CW(CW)) u_slot (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .count   (count),
    .digit   (digit),
    .wrap    (wrap),
    .frame   (frame)
  );

  assign load_in    = '{value: value_i, dp: dp_i, en: digit_en_i, lzb: lzb_i};
  assign frame_o    = frame;
  assign load_ack_o = frame && (pend_vld || load_i);
  assign dark       = digit_dark(disp_q, digit);
  assign nibble_o   = disp_q.value[{digit, 2'b00} +: 4];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_BLANK;
    else         state_q <= state_d;
  end

  // State tracks the counter value that will be present after this edge.
  always_comb begin
    state_d = state_q;
    an_o    = 4'hF;
    dp_o    = 1'b1;
    if (wrap)                               state_d = ST_BLANK;
    else if (count == CW'(BLANK_CYCLES - 1)) state_d = ST_SHOW;
    if (state_q == ST_SHOW && !dark) begin
      an_o = ~(4'b0001 << digit);
      dp_o = ~disp_q.dp[digit];
    end
  end

  // Displayed content only changes at the frame boundary; a load on that
  // same cycle bypasses the pending register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_q   <= DISP_RESET;
      disp_q   <= DISP_RESET;
      pend_vld <= 1'b0;
    end else begin
      if (load_i) pend_q <= load_in;
      if (frame) begin
        pend_vld <= 1'b0;
        if (load_i)        disp_q <= load_in;
        else if (pend_vld) disp_q <= pend_q;
      end else if (load_i) begin
        pend_vld <= 1'b1;
      end
    end
  end

endmodule
